gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_step.sv | 22 ++
 rtl/gcd_engine.sv | 134 +++++++++++++
 tb/tb_gcd_engine.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding and default operand width.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One subtractive-Euclid step: compare the two working operands and reduce the larger one.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] next_ra,
    output logic [WIDTH-1:0] next_rb
);

    assign eq     = (ra == rb);
    assign a_gt_b = (ra > rb);

    // Only the strictly larger operand is reduced, so neither difference can wrap.
    assign next_ra = a_gt_b ? (ra - rb) : ra;
    assign next_rb = (!eq && !a_gt_b) ? (rb - ra) : rb;

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine with valid/ready handshakes on operand and result sides.
// Defining GCD_ITER_COUNT_EN adds the iters output (CALC steps taken by the current job).
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef GCD_ITER_COUNT_EN
    output logic [WIDTH-1:0] iters,
`endif
    output logic             busy
);

    gcd_state_t       state_q;
    gcd_state_t       state_d;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] result_q;

    logic             step_eq;
    logic             step_gt;
    logic [WIDTH-1:0] step_ra;
    logic [WIDTH-1:0] step_rb;

    logic             accept;
    logic             zero_op;

    // clr wins over a handshake offered in the same cycle.
    assign accept  = (state_q == IDLE) && in_valid && !clr;
    assign zero_op = (a == '0) || (b == '0);

    gcd_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .ra      (ra_q),
        .rb      (rb_q),
        .eq      (step_eq),
        .a_gt_b  (step_gt),
        .next_ra (step_ra),
        .next_rb (step_rb)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = zero_op ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (step_eq) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A zero operand short-circuits straight to the result register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
        end else if (!clr) begin
            if (accept) begin
                if (zero_op) begin
                    result_q <= a | b;
                end else begin
                    ra_q <= a;
                    rb_q <= b;
                end
            end else if (state_q == CALC) begin
                if (step_eq) begin
                    result_q <= ra_q;
                end else if (step_gt) begin
                    ra_q <= step_ra;
                end else begin
                    rb_q <= step_rb;
                end
            end
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iters_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            iters_q <= '0;
        end else if (clr || accept) begin
            iters_q <= '0;
        end else if ((state_q == CALC) && (iters_q != '1)) begin
            iters_q <= iters_q + 1'b1;
        end
    end

    assign iters = iters_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine (WIDTH=8): vector table, random jobs vs. Euclid model, corner sequences.
module tb_gcd_engine;

    localparam int WIDTH = 8;
    localparam int MAX_WAIT = 400;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [WIDTH-1:0] result;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iters;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        int unsigned      expG;
        int unsigned      expIt;
    } vec_t;

    vec_t vecs[$];

    always #5 sys_clk = ~sys_clk;

    gcd_engine #(
        .WIDTH(WIDTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef GCD_ITER_COUNT_EN
        .iters     (iters),
`endif
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
    endtask

    // Euclid by division: gcd, and the subtractive step count equals the sum of the quotients.
    function automatic void refModel(input int unsigned x, input int unsigned y,
                                     output int unsigned g, output int unsigned it);
        int unsigned hi, lo, r;
        it = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
            return;
        end
        hi = (x > y) ? x : y;
        lo = (x > y) ? y : x;
        forever begin
            it += hi / lo;
            r = hi % lo;
            if (r == 0) begin
                g = lo;
                break;
            end
            hi = lo;
            lo = r;
        end
        if (it > (2 ** WIDTH) - 1) it = (2 ** WIDTH) - 1;
    endfunction

    // Runs one job with out_ready high; latency counted in edges from the cycle the offer is made.
    task automatic runJob(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input int unsigned expG, input int unsigned expIt);
        int  n;
        bit  seen;
        int  expLat;
        expLat = (va == 0 || vb == 0) ? 1 : int'(expIt) + 1;
        checkOutput({name, " in_ready"}, in_ready, 1);
        applyStimulus(va, vb);
        n    = 0;
        seen = 0;
        while (!seen && n < MAX_WAIT) begin
            tick();
            n++;
            if (n == 1) in_valid = 1'b0;
            if (out_valid) seen = 1;
        end
        in_valid = 1'b0;
        checkOutput({name, " latency"}, n, expLat);
        if (seen) begin
            checkOutput({name, " result"}, result, expG);
`ifdef GCD_ITER_COUNT_EN
            checkOutput({name, " iters"}, iters, expIt);
`endif
            tick();
            checkOutput({name, " back to idle"}, busy, 0);
        end
    endtask

    initial begin
        int unsigned g, it;
        int          n;
        bit          seenValid;
        logic [WIDTH-1:0] ra, rb;

        vecs.push_back('{8'd12,  8'd18,  6,   3});
        vecs.push_back('{8'd0,   8'd35,  35,  0});
        vecs.push_back('{8'd0,   8'd0,   0,   0});
        vecs.push_back('{8'd35,  8'd0,   35,  0});
        vecs.push_back('{8'd1,   8'd255, 1,   255});
        vecs.push_back('{8'd21,  8'd14,  7,   3});
        vecs.push_back('{8'd7,   8'd7,   7,   1});
        vecs.push_back('{8'd255, 8'd255, 255, 1});
        vecs.push_back('{8'd128, 8'd96,  32,  4});

        // Reset state, observed while reset is still asserted.
        #12;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset busy", busy, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        checkOutput("reset in_ready", in_ready, 1);
`ifdef GCD_ITER_COUNT_EN
        checkOutput("reset iters", iters, 0);
`endif

        foreach (vecs[i]) begin
            runJob($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].expG, vecs[i].expIt);
        end

        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            if (i % 7 == 3) ra = '0;
            refModel(ra, rb, g, it);
            runJob($sformatf("rand%0d(%0d,%0d)", i, ra, rb), ra, rb, g, it);
        end

        // Back-pressure in DONE, with operand changes during CALC/DONE ignored.
        out_ready = 1'b0;
        applyStimulus(8'd12, 8'd18);
        tick();
        a = 8'd50;
        b = 8'd5;
        n = 0;
        while (!out_valid && n < MAX_WAIT) begin
            tick();
            n++;
        end
        checkOutput("bp latency", n, 3);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp hold%0d out_valid", i), out_valid, 1);
            checkOutput($sformatf("bp hold%0d result", i), result, 6);
            checkOutput($sformatf("bp hold%0d in_ready", i), in_ready, 0);
            tick();
        end
`ifdef GCD_ITER_COUNT_EN
        checkOutput("bp iters", iters, 3);
`endif
        out_ready = 1'b1;
        checkOutput("bp release out_valid", out_valid, 1);
        tick();
        checkOutput("bp after release out_valid", out_valid, 0);
        checkOutput("bp after release in_ready", in_ready, 1);

        // clr in the middle of a CALC run.
        applyStimulus(8'd100, 8'd75);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("clr pre busy", busy, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr busy", busy, 0);
        checkOutput("clr in_ready", in_ready, 1);
        seenValid = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seenValid = 1;
            tick();
        end
        checkOutput("clr no out_valid", seenValid, 0);
        runJob("after clr", 8'd21, 8'd14, 7, 3);

        // Asynchronous reset while holding a result in DONE.
        out_ready = 1'b0;
        applyStimulus(8'd12, 8'd18);
        n = 0;
        while (!out_valid && n < MAX_WAIT) begin
            tick();
            n++;
            if (n == 1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checkOutput("rst pre out_valid", out_valid, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst async out_valid", out_valid, 0);
        checkOutput("rst async result", result, 0);
        checkOutput("rst async busy", busy, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("rst release in_ready", in_ready, 1);
        runJob("after rst", 8'd0, 8'd0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
